fetch_ctrl: RTL
===============

Name: fetch_ctrl

Overview:
Instruction-fetch sequencer for the single-cycle-read, byte-addressed, big-endian instruction memory. The block owns the PC and drives the memory address. It registers each returned word into the IF/ID interface using a valid/ready handshake. It also handles branch/jump redirects, halt requests, and address faults (misaligned or out of range). It sits between the PC-update logic of the core and the instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MEM_BYTES, 421, instruction memory size in bytes; a fetch is legal only if pc <= MEM_BYTES-4
Test Plan scenarios below use the defaults.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  leave IDLE, or resume from a non-fault HALT
pc_addr  output  32  address to instruction memory; equals the internal pc register (combinational)
instr_in  input  32  word returned by memory for pc_addr in the same cycle
out_valid  output  1  out_instr/out_pc hold a fetched instruction
out_ready  input  1  downstream accepts the instruction this cycle
out_instr  output  32  fetched instruction
out_pc  output  32  address of out_instr
redirect_valid  input  1  branch/jump taken; flush and refetch
redirect_pc  input  32  redirect target
halt_req  input  1  stop fetching
halted  output  1  state is HALT
fault  output  1  sticky fetch-address fault
fetch_count  output  32  number of instructions fetched, wraps at 2^32

Behaviour:
- Reset (async, immediate): pc=RESET_PC, state=IDLE, out_valid=0, out_instr=0, out_pc=0, halted=0, fault=0, fetch_count=0.
- States: IDLE, FETCH, HALT. halted=1 only in HALT.
- Slot free: slot_free = !out_valid || out_ready.
- IDLE:
  - No fetch.
  - redirect_valid loads pc=redirect_pc and stays in IDLE.
  - start moves to FETCH. If both are asserted, apply the redirect and go to FETCH.
  - halt_req is ignored.
- FETCH: priority per cycle is redirect > halt_req > fault check > fetch.
  - redirect_valid: pc<=redirect_pc, out_valid<=0. This applies even when stalled; the held instruction is discarded. No fetch that cycle.
  - halt_req: go to HALT. out_valid<=0 if out_ready, otherwise held. No fetch.
  - Fault check, only when slot_free: if pc[1:0]!=0 or pc > MEM_BYTES-4 (evaluate in 33 bits, no overflow), then fault<=1, out_valid<=0, go to HALT. pc is held at the faulting address.
  - Fetch, when slot_free: out_instr<=instr_in, out_pc<=pc, out_valid<=1, pc<=pc+4, fetch_count<=fetch_count+1.
  - Stall (!slot_free, no redirect/halt): all registers hold; pc_addr unchanged.
- HALT:
  - No fetch. A pending out_valid clears once out_ready is seen.
  - redirect_valid is ignored.
  - start with fault=0 resumes FETCH at the current pc. start with fault=1 is ignored.
  - Only rst clears fault.
- Latency:
  - A word is presented at pc_addr in cycle N and appears on out_instr at N+1.
  - Sustained throughput is 1 instruction/cycle with out_ready=1.
  - The first out_valid occurs 1 cycle after the cycle in which start is sampled in IDLE, plus 1 cycle before FETCH begins (start sampled → FETCH → first fetch edge).
- pc+4 wraps modulo 2^32. The resulting address is caught by the range check.
- Reset during a stall or redirect aborts everything immediately; no partial update survives.

Test Plan:
- Reset; memory bytes 0..11 = 00 01 02 03, 10 11 12 13, 20 21 22 23; start pulse; out_ready=1 → out_pc 0,4,8 on consecutive cycles; out_instr 32'h00010203, 32'h10111213, 32'h20212223; fetch_count=3.
- Backpressure: out_ready=0 for 3 cycles while out_pc=4 → out_instr/out_pc/out_valid held, pc_addr stays 8, fetch_count unchanged. Raise out_ready → out_pc=8 next cycle.
- Redirect while stalled: redirect_valid=1, redirect_pc=32'h40, out_ready=0 → next cycle out_valid=0, pc_addr=32'h40. Following cycle out_pc=32'h40, out_valid=1.
- Misaligned redirect to 32'h42 → no new out_valid, fault=1, halted=1, pc_addr=32'h42. start is ignored. rst clears fault/halted, and pc_addr=RESET_PC.
- Range boundary: redirect to 32'd412, run → pcs 412 and 416 fetched; at pc 420, fault=1 and halted=1.
- halt_req at out_pc=4 with out_ready=1 → halted=1, out_valid=0, fetch_count frozen. start → fetching resumes at pc 8. Async rst asserted mid-cycle → all outputs zero before the next edge.

Source files
------------

// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer. Owns the PC, drives the memory
// address, and registers each returned word into a valid/ready output slot.
// Handles redirects, halt requests and sticky address faults.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          MEM_BYTES = 421
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic [31:0] pc_addr,
    input  logic [31:0] instr_in,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        halt_req,
    output logic        halted,
    output logic        fault,
    output logic [31:0] fetch_count
);

    typedef enum logic [1:0] {IDLE, FETCH, HALT} state_t;

    // Highest legal word address, widened so pc near 2^32 cannot wrap past it.
    localparam logic [32:0] LAST_PC = 33'(MEM_BYTES - 4);

    state_t      state, state_nx;
    logic [31:0] pc, pc_nx;
    logic        out_valid_nx;
    logic [31:0] out_instr_nx, out_pc_nx;
    logic        fault_nx;
    logic [31:0] fetch_count_nx;

    logic slot_free;
    logic addr_bad;

    assign slot_free = !out_valid || out_ready;
    assign addr_bad  = (pc[1:0] != 2'b00) || ({1'b0, pc} > LAST_PC);

    assign pc_addr = pc;
    assign halted  = (state == HALT);

    // State and datapath registers; reset wipes everything immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            out_valid   <= 1'b0;
            out_instr   <= 32'h0;
            out_pc      <= 32'h0;
            fault       <= 1'b0;
            fetch_count <= 32'h0;
        end else begin
            state       <= state_nx;
            pc          <= pc_nx;
            out_valid   <= out_valid_nx;
            out_instr   <= out_instr_nx;
            out_pc      <= out_pc_nx;
            fault       <= fault_nx;
            fetch_count <= fetch_count_nx;
        end
    end

    // Next-state and datapath: redirect > halt > fault check > fetch in FETCH.
    always_comb begin
        state_nx       = state;
        pc_nx          = pc;
        out_valid_nx   = out_valid;
        out_instr_nx   = out_instr;
        out_pc_nx      = out_pc;
        fault_nx       = fault;
        fetch_count_nx = fetch_count;
        unique case (state)
            IDLE: begin
                if (redirect_valid) pc_nx = redirect_pc;
                if (start)          state_nx = FETCH;
            end
            FETCH: begin
                if (redirect_valid) begin
                    // Held instruction is discarded even under backpressure.
                    pc_nx        = redirect_pc;
                    out_valid_nx = 1'b0;
                end else if (halt_req) begin
                    state_nx = HALT;
                    if (out_ready) out_valid_nx = 1'b0;
                end else if (slot_free) begin
                    if (addr_bad) begin
                        // pc stays on the faulting address for debug.
                        fault_nx     = 1'b1;
                        out_valid_nx = 1'b0;
                        state_nx     = HALT;
                    end else begin
                        out_instr_nx   = instr_in;
                        out_pc_nx      = pc;
                        out_valid_nx   = 1'b1;
                        pc_nx          = pc + 32'd4;
                        fetch_count_nx = fetch_count + 32'd1;
                    end
                end
            end
            HALT: begin
                // Drain any held instruction; only a clean halt can resume.
                if (out_ready)         out_valid_nx = 1'b0;
                if (start && !fault)   state_nx = FETCH;
            end
            default: state_nx = IDLE;
        endcase
    end

endmodule
